// File: rtl/hazard_flush_ctrl.sv
// Hazard and flush controller for the 16-bit five-stage pipeline.
// Drives PC/IF-ID enables, ID/EX and IF/ID flushes, freeze, and event counters.
module hazard_flush_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [2:0]       id_rs_i,
    input  logic [2:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic [2:0]       ex_rt_reg_i,
    input  logic             ex_branch_taken_i,
    input  logic             id_jump_i,
    input  logic             mem_busy_i,
    input  logic             cnt_clr_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             data_id_ex_flush_o,
    output logic             branch_id_ex_flush_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_LSTALL = 2'd1;
    localparam logic [1:0] S_FREEZE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       ret_q, ret_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic luh;
    logic pc_we, ifid_we, ifid_fl, data_fl, br_fl, frz;
    logic stall_inc, flush_inc;

    assign luh = ex_mem_read_i && (ex_rt_reg_i != 3'd0) &&
                 ((ex_rt_reg_i == id_rs_i) ||
                  (id_uses_rt_i && (ex_rt_reg_i == id_rt_i)));

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        bcnt_d  = bcnt_q;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        ifid_fl = 1'b0;
        data_fl = 1'b0;
        br_fl   = 1'b0;
        frz     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mem_busy_i) begin
                    frz     = 1'b1;
                    ret_d   = S_RUN;
                    state_d = S_FREEZE;
                end else if (ex_branch_taken_i) begin
                    pc_we   = 1'b1;
                    ifid_fl = 1'b1;
                    br_fl   = 1'b1;
                end else if (luh) begin
                    data_fl = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        bcnt_d  = 3'(LOAD_STALL_CYCLES - 2);
                        state_d = S_LSTALL;
                    end
                end else if (id_jump_i) begin
                    pc_we   = 1'b1;
                    ifid_fl = 1'b1;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            end
            S_LSTALL: begin
                // EX holds a bubble here, so branch/jump inputs are stale
                if (mem_busy_i) begin
                    frz     = 1'b1;
                    ret_d   = S_LSTALL;
                    state_d = S_FREEZE;
                end else begin
                    data_fl = 1'b1;
                    if (bcnt_q == 3'd0) begin
                        state_d = S_RUN;
                    end else begin
                        bcnt_d = bcnt_q - 3'd1;
                    end
                end
            end
            S_FREEZE: begin
                frz = 1'b1;
                if (!mem_busy_i) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign pc_write_o           = pc_we & rst_n;
    assign if_id_write_o        = ifid_we & rst_n;
    assign if_id_flush_o        = ifid_fl & rst_n;
    assign data_id_ex_flush_o   = data_fl & rst_n;
    assign branch_id_ex_flush_o = br_fl & rst_n;
    assign pipe_freeze_o        = frz & rst_n;

    assign stall_inc = ~pc_write_o;
    assign flush_inc = if_id_flush_o | data_id_ex_flush_o | branch_id_ex_flush_o;

    // Clear wins over increment; increments saturate at all-ones
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (cnt_clr_i) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (stall_inc && (stall_q != '1)) begin
                stall_d = stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_d = flush_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            ret_q   <= S_RUN;
            bcnt_q  <= 3'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bcnt_q  <= bcnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl with LOAD_STALL_CYCLES=1 and =3.
// Expected control vectors are queued on drive and checked mid-cycle.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rs = 0, rt = 0, exrt = 0;
    logic       urt = 0, mr = 0, br = 0, jmp = 0, busy = 0, clr = 0;

    logic        a_pc, a_ifw, a_iff, a_df, a_bf, a_frz;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifw, b_iff, b_df, b_bf, b_frz;
    logic [3:0]  b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
        .clk_i(clk), .rst_n(rst_n),
        .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(urt),
        .ex_mem_read_i(mr), .ex_rt_reg_i(exrt),
        .ex_branch_taken_i(br), .id_jump_i(jmp),
        .mem_busy_i(busy), .cnt_clr_i(clr),
        .pc_write_o(a_pc), .if_id_write_o(a_ifw), .if_id_flush_o(a_iff),
        .data_id_ex_flush_o(a_df), .branch_id_ex_flush_o(a_bf),
        .pipe_freeze_o(a_frz), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
    );

    hazard_flush_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u3 (
        .clk_i(clk), .rst_n(rst_n),
        .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(urt),
        .ex_mem_read_i(mr), .ex_rt_reg_i(exrt),
        .ex_branch_taken_i(br), .id_jump_i(jmp),
        .mem_busy_i(busy), .cnt_clr_i(clr),
        .pc_write_o(b_pc), .if_id_write_o(b_ifw), .if_id_flush_o(b_iff),
        .data_id_ex_flush_o(b_df), .branch_id_ex_flush_o(b_bf),
        .pipe_freeze_o(b_frz), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
    );

    // ctrl order: pc_write, if_id_write, if_id_flush, data_flush, branch_flush, freeze
    localparam logic [5:0] NORM = 6'b110000;
    localparam logic [5:0] LUH  = 6'b000100;
    localparam logic [5:0] BR   = 6'b101010;
    localparam logic [5:0] JMP  = 6'b101000;
    localparam logic [5:0] FRZ  = 6'b000001;
    localparam logic [5:0] ZERO = 6'b000000;

    typedef struct {
        string       tag;
        logic [5:0]  ctrl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t        sbq[$];
    int          nvec = 0;
    int          nerr = 0;
    logic        sel3 = 1'b0;
    logic [15:0] m_sc = 0, m_fc = 0;

    function automatic logic [5:0] obs_ctrl();
        if (sel3) return {b_pc, b_ifw, b_iff, b_df, b_bf, b_frz};
        return {a_pc, a_ifw, a_iff, a_df, a_bf, a_frz};
    endfunction

    function automatic logic [15:0] obs_sc();
        return sel3 ? {12'd0, b_sc} : a_sc;
    endfunction

    function automatic logic [15:0] obs_fc();
        return sel3 ? {12'd0, b_fc} : a_fc;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL scoreboard_empty");
            return;
        end
        e = sbq.pop_front();
        chk({e.tag, "_ctrl"},  {10'd0, obs_ctrl()}, {10'd0, e.ctrl});
        chk({e.tag, "_stall"}, obs_sc(), e.sc);
        chk({e.tag, "_flush"}, obs_fc(), e.fc);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cyc(input string tag,
                       input logic [2:0] i_rs, input logic [2:0] i_rt,
                       input logic i_urt, input logic i_mr,
                       input logic [2:0] i_exrt, input logic i_br,
                       input logic i_jmp, input logic i_busy,
                       input logic i_clr, input logic [5:0] ec);
        logic [15:0] cmax;
        rs = i_rs; rt = i_rt; urt = i_urt; mr = i_mr; exrt = i_exrt;
        br = i_br; jmp = i_jmp; busy = i_busy; clr = i_clr;
        sbq.push_back('{tag, ec, m_sc, m_fc});
        #2;
        pop_check();
        cmax = sel3 ? 16'd15 : 16'hFFFF;
        if (i_clr) begin
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (!ec[5] && m_sc != cmax) m_sc++;
            if ((|ec[3:1]) && m_fc != cmax) m_fc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag, input logic hold_busy);
        rs = 0; rt = 0; urt = 0; mr = 0; exrt = 0;
        br = 0; jmp = 0; clr = 0; busy = hold_busy;
        rst_n = 1'b0;
        m_sc = 0;
        m_fc = 0;
        sbq.push_back('{tag, ZERO, 16'd0, 16'd0});
        #2;
        pop_check();
        @(negedge clk);
        busy = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        sel3 = 1'b0;
        do_reset("rst1", 1'b0);
        //   tag        rs rt urt mr exrt br jmp busy clr exp
        cyc("a_luh",    3, 0, 0, 1, 3, 0, 0, 0, 0, LUH);
        cyc("a_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
        cyc("a_r0",     0, 0, 0, 1, 0, 0, 0, 0, 0, NORM);
        cyc("a_nort",   1, 5, 0, 1, 5, 0, 0, 0, 0, NORM);
        cyc("a_rt",     1, 5, 1, 1, 5, 0, 0, 0, 0, LUH);
        cyc("a_brpri",  4, 0, 0, 1, 4, 1, 1, 0, 0, BR);
        cyc("a_jmp",    0, 0, 0, 0, 0, 0, 1, 0, 0, JMP);
        cyc("a_norm",   2, 3, 1, 0, 0, 0, 0, 0, 0, NORM);

        sel3 = 1'b1;
        do_reset("rst3", 1'b0);
        cyc("b_luh0",   3, 0, 0, 1, 3, 0, 0, 0, 0, LUH);
        cyc("b_luh1",   0, 0, 0, 0, 0, 1, 1, 0, 0, LUH);
        cyc("b_luh2",   0, 0, 0, 0, 0, 0, 0, 0, 0, LUH);
        cyc("b_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
        cyc("b_fl0",    0, 6, 1, 1, 6, 0, 0, 0, 0, LUH);
        cyc("b_fz0",    0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
        cyc("b_fz1",    0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
        cyc("b_fz2",    0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ);
        cyc("b_res1",   0, 0, 0, 0, 0, 0, 0, 0, 0, LUH);
        cyc("b_res2",   0, 0, 0, 0, 0, 0, 0, 0, 0, LUH);
        cyc("b_run2",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
        cyc("b_rl0",    2, 0, 0, 1, 2, 0, 0, 0, 0, LUH);
        cyc("b_rfz0",   0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
        cyc("b_rfz1",   0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
        do_reset("b_rstfz", 1'b1);
        cyc("b_post0",  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
        cyc("b_post1",  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
        cyc("b_rbusy",  0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ);
        cyc("b_rfree",  0, 0, 0, 0, 0, 0, 0, 0, 0, FRZ);
        cyc("b_rback",  0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

        for (int i = 0; i < 20; i++) begin
            cyc("b_sat",  1, 0, 0, 1, 1, 0, 0, 0, 0, LUH);
        end
        cyc("b_clr",    1, 0, 0, 1, 1, 0, 0, 0, 1, LUH);
        cyc("b_clr1",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
        cyc("b_clr2",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
